rate_generator: RTL and testbench
=================================

# rate_generator

Transmit-side counterpart of the rate recovery path: synthesises an IO line whose edge spacing is set by a programmed rate, either as a plain clock or as Manchester-encoded (clock-encoded) data. It sits between a bit source (valid/ready) and the IO pad. When its output is looped into the recovery path, that path must lock to the same `rate_i`.

## Interface
Parameters: none. Widths come from `clks_alot_p`.

Ports:
- `sys_dom_i`  input  `common_p::clk_dom_s`  system clock domain bundle. One clock. Reset is asynchronous and active-low.
- `gen_en_i`  input  1  enables generation. Deassertion is graceful (see Operation).
- `clear_state_i`  input  1  synchronous abort to IDLE. Priority over everything except reset.
- `clock_encoded_data_en_i`  input  1  1 = Manchester data mode, 0 = plain clock mode.
- `idle_level_i`  input  1  line level while in IDLE.
- `rate_i`  input  `RATE_COUNTER_WIDTH`  half-period length minus 1, in sys clocks.
- `data_valid_i`  input  1  bit offered (data mode only).
- `data_i`  input  1  bit value.
- `data_ready_o`  output  1  bit accepted when valid && ready.
- `io_o`  output  1  registered line output.
- `rising_edge_o`, `falling_edge_o`, `any_edge_o`  output  1 each  single-cycle pulses, asserted in the same cycle `io_o` shows the new level.
- `mid_bit_o`  output  1  pulse on a mid-bit edge (data mode). This is the primary event in recovery terms.
- `underrun_o`  output  1  pulse when a bit boundary is reached with no valid data.
- `busy_o`  output  1  state != IDLE.

## Operation
- States: IDLE, FIRST_HALF, SECOND_HALF.
- **Half-period timing.** Timer loads 0 on entering a half, increments each cycle, and the half ends when timer == `rate_q`. Each half therefore lasts `rate_q`+1 cycles.
- **Rate sampling.** `rate_q` samples `rate_i` only on entering FIRST_HALF, so a rate change takes effect at the next bit/period start and never mid-period.
- **IDLE.**
  - `io_o` <= `idle_level_i`.
  - Data mode: `data_ready_o`=1 while `gen_en_i`.
  - Leaves to FIRST_HALF when `gen_en_i` is set and, in data mode, valid && ready.
- **Data mode (IEEE 802.3 convention).** For bit b, FIRST_HALF level = ~b and SECOND_HALF level = b.
  - Entering FIRST_HALF: edge only if the line differs from ~b (boundary edge).
  - Entering SECOND_HALF: always an edge; `mid_bit_o`=1.
- **End of SECOND_HALF.**
  - `data_ready_o` is asserted combinationally in the last cycle.
  - If `gen_en_i` && valid: the next bit is captured and FIRST_HALF starts next cycle.
  - If `gen_en_i` && !valid: `underrun_o` pulses and the state goes to IDLE.
  - If !`gen_en_i`: the state goes to IDLE with no underrun.
- **Clock mode.** FIRST_HALF drives `~idle_level_q` and SECOND_HALF drives `idle_level_q` (`idle_level_i` is captured at start). `data_*` is ignored and `data_ready_o`=0. At the end of SECOND_HALF the FSM loops if `gen_en_i`, else goes to IDLE.
- **Mode change.** `clock_encoded_data_en_i` is sampled only in IDLE.
- **Graceful stop.** `gen_en_i` dropping mid-bit completes the current bit/period before IDLE.
- **clear_state_i.**
  - Next cycle: IDLE, timer=0, `io_o`=`idle_level_i`.
  - Any edge this causes is flagged normally.
  - No underrun.
- **Reset values.** State IDLE, `io_o`=0, `rate_q`=0, all pulses 0, `data_ready_o`=0.

## Timing
- Accept at cycle t (valid && ready in IDLE) gives first `io_o` level at t+1. The mid-bit edge is at t+1+(`rate_q`+1).
- Bit period = 2×(`rate_q`+1) cycles, with back-to-back bits and no bubble.
- `rate_i`=0 is legal: the line changes every cycle in clock mode.
- Edge pulses are registered alongside `io_o`: zero skew between them.
- `rate_i`=max: the timer must not wrap. The compare is equality, and the timer width is `RATE_COUNTER_WIDTH`.

## Structure
- `clks_alot_p` gains the `rate_gen_state_e` enum (IDLE/FIRST_HALF/SECOND_HALF).
- `RATE_COUNTER_WIDTH` is reused as-is.
- Half-period timer uses the existing `counter` module:
  - growth 1, seed 0;
  - clear on half end or `clear_state_i`;
  - enable = `busy_o`.
- No other sub-modules. The FSM, line register and edge flags are local.

## Test plan
- **Clock mode.** `rate_i`=3, idle 0, `gen_en_i` held → `io_o` toggles every 4 cycles. Rising/falling pulses alternate and coincide with `io_o` changes.
- **Data mode.** `rate_i`=2, bits 1,1,0 back-to-back → levels 0,1,0,1,1,0 each for 3 cycles. `mid_bit_o` pulses 3 times; boundary edges only between 1→1.
- **Underrun.** Valid drops after one bit → `underrun_o` pulses in the cycle after the end of SECOND_HALF. IDLE with `io_o`=`idle_level_i`.
- **Rate change mid-bit.** `rate_i` changes 5→1 → current bit keeps 6-cycle halves, next bit uses 2-cycle halves.
- **Aborts.**
  - `clear_state_i` in FIRST_HALF → IDLE next cycle, no `underrun_o`.
  - Async reset mid-bit → `io_o`=0, `busy_o`=0 immediately.
- **Loopback.** `io_o` fed into rate_recovery with `rate_i`=7 → recovery locks with `rate_o`=7.

Source files
------------

// File: rtl/rate_generator_pkg.sv
// Shared types for the rate generator: the clock-domain bundle and the
// rate-path package holding the counter width and generator state encoding.

package common_p;

   // One clock plus its asynchronous active-low reset.
   typedef struct packed {
      logic clk;
      logic rst_n;
   } clk_dom_s;

endpackage : common_p

package clks_alot_p;

   // Width of every rate counter and of the programmed rate value.
   localparam int RATE_COUNTER_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      FIRST_HALF  = 2'd1,
      SECOND_HALF = 2'd2
   } rate_gen_state_e;

endpackage : clks_alot_p

// File: rtl/rate_generator_counter.sv
// Generic up-counter with seed and growth step. Clear wins over enable,
// so a single-cycle clear always restarts the count at the seed.

module counter #(
   parameter int          WIDTH  = 8,
   parameter int unsigned GROWTH = 1,
   parameter int unsigned SEED   = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clear,
   output logic [WIDTH-1:0] count
);

   // Count register: restart at the seed on clear, otherwise step while enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= WIDTH'(SEED);
      end else if (clear) begin
         count <= WIDTH'(SEED);
      end else if (en) begin
         count <= count + WIDTH'(GROWTH);
      end
   end

endmodule : counter

// File: rtl/rate_generator.sv
// Rate generator: drives an IO line whose half-period is rate_q+1 system
// clocks, either as a free-running clock or as Manchester-encoded data
// (802.3 polarity: first half ~bit, second half bit).

module rate_generator
   import common_p::*;
   import clks_alot_p::*;
(
   input  clk_dom_s                      sys_dom_i,
   input  logic                          gen_en_i,
   input  logic                          clear_state_i,
   input  logic                          clock_encoded_data_en_i,
   input  logic                          idle_level_i,
   input  logic [RATE_COUNTER_WIDTH-1:0] rate_i,
   input  logic                          data_valid_i,
   input  logic                          data_i,
   output logic                          data_ready_o,
   output logic                          io_o,
   output logic                          rising_edge_o,
   output logic                          falling_edge_o,
   output logic                          any_edge_o,
   output logic                          mid_bit_o,
   output logic                          underrun_o,
   output logic                          busy_o
);

   logic clk;
   logic rst_n;
   assign clk   = sys_dom_i.clk;
   assign rst_n = sys_dom_i.rst_n;

   rate_gen_state_e                 state_q, state_d;
   logic [RATE_COUNTER_WIDTH-1:0]   rate_q;
   logic [RATE_COUNTER_WIDTH-1:0]   timer;
   logic                            mode_q;        // 1 = Manchester data mode
   logic                            idle_level_q;  // idle level captured at start
   logic                            bit_q;         // bit currently on the line
   logic                            half_end;
   logic                            level_d;
   logic                            load;          // entering FIRST_HALF
   logic                            start;         // entering FIRST_HALF from IDLE
   logic                            mid_d;
   logic                            underrun_d;

   assign busy_o   = (state_q != IDLE);
   assign half_end = busy_o && (timer == rate_q);

   // Half-period timer: restarts at 0 on every half boundary or abort.
   counter #(
      .WIDTH  (RATE_COUNTER_WIDTH),
      .GROWTH (1),
      .SEED   (0)
   ) u_half_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (busy_o),
      .clear (half_end || clear_state_i),
      .count (timer)
   );

   // Next-state, next line level and bit handshake decisions.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
      state_d      = state_q;
      level_d      = io_o;
      load         = 1'b0;
      start        = 1'b0;
      mid_d        = 1'b0;
      underrun_d   = 1'b0;
      data_ready_o = 1'b0;
      if (clear_state_i) begin
         state_d = IDLE;
         level_d = idle_level_i;
      end else begin
         case (state_q)
            IDLE: begin
               level_d      = idle_level_i;
               data_ready_o = gen_en_i && clock_encoded_data_en_i;
               if (gen_en_i && (!clock_encoded_data_en_i || data_valid_i)) begin
                  state_d = FIRST_HALF;
                  load    = 1'b1;
                  start   = 1'b1;
                  level_d = clock_encoded_data_en_i ? ~data_i : ~idle_level_i;
               end
            end
            FIRST_HALF: begin
               if (half_end) begin
                  state_d = SECOND_HALF;
                  level_d = mode_q ? bit_q : idle_level_q;
                  mid_d   = mode_q;
               end
            end
            SECOND_HALF: begin
               if (half_end) begin
                  data_ready_o = gen_en_i && mode_q;
                  if (gen_en_i && (!mode_q || data_valid_i)) begin
                     state_d = FIRST_HALF;
                     load    = 1'b1;
                     level_d = mode_q ? ~data_i : ~idle_level_q;
                  end else begin
                     state_d    = IDLE;
                     level_d    = idle_level_i;
                     underrun_d = gen_en_i && mode_q;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               level_d = idle_level_i;
            end
         endcase
      end
   end

   // State, line register and edge/event pulses, all updated together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         rate_q         <= '0;
         mode_q         <= 1'b0;
         idle_level_q   <= 1'b0;
         bit_q          <= 1'b0;
         io_o           <= 1'b0;
         rising_edge_o  <= 1'b0;
         falling_edge_o <= 1'b0;
         any_edge_o     <= 1'b0;
         mid_bit_o      <= 1'b0;
         underrun_o     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register sees pre-edge values, keeping io_o and its pulses aligned.
         state_q        <= state_d;
         io_o           <= level_d;
         rising_edge_o  <= level_d & ~io_o;
         falling_edge_o <= ~level_d & io_o;
         any_edge_o     <= level_d ^ io_o;
         mid_bit_o      <= mid_d;
         underrun_o     <= underrun_d;
         if (load) begin
            rate_q <= rate_i;
            bit_q  <= data_i;
         end
         if (start) begin
            mode_q       <= clock_encoded_data_en_i;
            idle_level_q <= idle_level_i;
         end
      end
   end

endmodule : rate_generator

// File: tb/tb_rate_generator.sv
// Directed bench for rate_generator: a per-cycle vector table for the
// Manchester data path, plus hand-written clock-mode, rate-change, abort
// and asynchronous-reset sequences.

module tb_rate_generator;
   import common_p::*;
   import clks_alot_p::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   clk_dom_s sys_dom;
   assign sys_dom.clk   = clk;
   assign sys_dom.rst_n = rst_n;

   logic                          gen_en = 1'b0;
   logic                          clear_state = 1'b0;
   logic                          mode = 1'b0;
   logic                          idle_level = 1'b0;
   logic [RATE_COUNTER_WIDTH-1:0] rate = '0;
   logic                          data_valid = 1'b0;
   logic                          data = 1'b0;
   logic data_ready, io, rising_edge, falling_edge, any_edge, mid_bit, underrun, busy;

   int checks = 0;
   int errors = 0;

   rate_generator dut (
      .sys_dom_i               (sys_dom),
      .gen_en_i                (gen_en),
      .clear_state_i           (clear_state),
      .clock_encoded_data_en_i (mode),
      .idle_level_i            (idle_level),
      .rate_i                  (rate),
      .data_valid_i            (data_valid),
      .data_i                  (data),
      .data_ready_o            (data_ready),
      .io_o                    (io),
      .rising_edge_o           (rising_edge),
      .falling_edge_o          (falling_edge),
      .any_edge_o              (any_edge),
      .mid_bit_o               (mid_bit),
      .underrun_o              (underrun),
      .busy_o                  (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   typedef struct {
      logic gen_en, valid, data;
      logic ready, io, rise, fall, mid, under, busy;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic g, input logic v, input logic d, input logic rdy,
                          input logic l, input logic r, input logic f, input logic m,
                          input logic u, input logic b);
      vec_t x;
      x.gen_en = g; x.valid = v; x.data = d;
      x.ready = rdy; x.io = l; x.rise = r; x.fall = f; x.mid = m; x.under = u; x.busy = b;
      vecs.push_back(x);
   endtask

   task automatic edge_wait();
      @(posedge clk);
      #1;
   endtask

   task automatic settle(input logic m, input logic idl);
      @(negedge clk);
      gen_en = 1'b0; mode = m; idle_level = idl; data_valid = 1'b0; clear_state = 1'b0;
      edge_wait();
      edge_wait();
   endtask

   // Clock mode run: gen_en held through edge 'stop', then dropped; the
   // current period must complete before IDLE.
   task automatic run_clock(input int r, input logic idl, input int stop);
      int   h, e;
      logic prev, exp_io;
      h = r + 1;
      e = (stop / (2 * h) + 1) * (2 * h);
      settle(1'b0, idl);
      prev = idl;
      for (int i = 0; i < e + 2; i++) begin
         @(negedge clk);
         gen_en     = (i <= stop);
         rate       = RATE_COUNTER_WIDTH'(r);
         data_valid = 1'b1;
         data       = 1'b1;
         #1;
         if (i == 0) check($sformatf("clk r%0d ready", r), data_ready, 1'b0);
         edge_wait();
         exp_io = (i < e) ? (((i / h) % 2 == 0) ? ~idl : idl) : idl;
         check($sformatf("clk r%0d io e%0d", r, i), io, exp_io);
         check($sformatf("clk r%0d rise e%0d", r, i), rising_edge, exp_io & ~prev);
         check($sformatf("clk r%0d fall e%0d", r, i), falling_edge, ~exp_io & prev);
         check($sformatf("clk r%0d busy e%0d", r, i), busy, (i < e));
         check($sformatf("clk r%0d mid e%0d", r, i), mid_bit, 1'b0);
         prev = exp_io;
      end
   endtask

   initial begin
      logic rc_io[18];

      // Reset state while rst_n is held low.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset io", io, 1'b0);
      check("reset busy", busy, 1'b0);
      check("reset ready", data_ready, 1'b0);
      check("reset pulses", {rising_edge, falling_edge, any_edge, mid_bit, underrun}, 5'b0);
      rst_n = 1'b1;

      // Data mode table: rate 2, bits 1,1,0 back-to-back, then underrun.
      //       gen v  d  rdy io r  f  m  u  busy
      add_vec(1, 1, 1, 1,  0, 0, 0, 0, 0, 1);
      add_vec(1, 0, 0, 0,  0, 0, 0, 0, 0, 1);
      add_vec(1, 0, 0, 0,  0, 0, 0, 0, 0, 1);
      add_vec(1, 0, 0, 0,  1, 1, 0, 1, 0, 1);
      add_vec(1, 0, 0, 0,  1, 0, 0, 0, 0, 1);
      add_vec(1, 0, 0, 0,  1, 0, 0, 0, 0, 1);
      add_vec(1, 1, 1, 1,  0, 0, 1, 0, 0, 1);
      add_vec(1, 0, 0, 0,  0, 0, 0, 0, 0, 1);
      add_vec(1, 0, 0, 0,  0, 0, 0, 0, 0, 1);
      add_vec(1, 0, 0, 0,  1, 1, 0, 1, 0, 1);
      add_vec(1, 0, 0, 0,  1, 0, 0, 0, 0, 1);
      add_vec(1, 0, 0, 0,  1, 0, 0, 0, 0, 1);
      add_vec(1, 1, 0, 1,  1, 0, 0, 0, 0, 1);
      add_vec(1, 0, 0, 0,  1, 0, 0, 0, 0, 1);
      add_vec(1, 0, 0, 0,  1, 0, 0, 0, 0, 1);
      add_vec(1, 0, 0, 0,  0, 0, 1, 1, 0, 1);
      add_vec(1, 0, 0, 0,  0, 0, 0, 0, 0, 1);
      add_vec(1, 0, 0, 0,  0, 0, 0, 0, 0, 1);
      add_vec(1, 0, 0, 1,  0, 0, 0, 0, 1, 0);
      add_vec(0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

      settle(1'b1, 1'b0);
      rate = RATE_COUNTER_WIDTH'(2);
      foreach (vecs[k]) begin
         @(negedge clk);
         gen_en = vecs[k].gen_en; data_valid = vecs[k].valid; data = vecs[k].data;
         #1;
         check($sformatf("data v%0d ready", k), data_ready, vecs[k].ready);
         edge_wait();
         check($sformatf("data v%0d io", k), io, vecs[k].io);
         check($sformatf("data v%0d rise", k), rising_edge, vecs[k].rise);
         check($sformatf("data v%0d fall", k), falling_edge, vecs[k].fall);
         check($sformatf("data v%0d any", k), any_edge, vecs[k].rise | vecs[k].fall);
         check($sformatf("data v%0d mid", k), mid_bit, vecs[k].mid);
         check($sformatf("data v%0d underrun", k), underrun, vecs[k].under);
         check($sformatf("data v%0d busy", k), busy, vecs[k].busy);
      end

      // Clock mode: rate 3 idle 0, rate 0 (toggle every cycle), rate 1 idle 1.
      run_clock(3, 1'b0, 24);
      run_clock(0, 1'b0, 5);
      run_clock(1, 1'b1, 6);

      // Rate change 5 -> 1 during a bit: bit 1 keeps 6-cycle halves, bit 0 uses 2.
      rc_io = '{0,0,0,0,0,0,1,1,1,1,1,1,1,1,0,0,0,0};
      settle(1'b1, 1'b0);
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         rate       = RATE_COUNTER_WIDTH'((i == 0) ? 5 : 1);
         gen_en     = (i <= 12);
         data_valid = (i <= 12);
         data       = (i == 0);
         edge_wait();
         check($sformatf("rate chg io e%0d", i), io, rc_io[i]);
         check($sformatf("rate chg mid e%0d", i), mid_bit, (i == 6 || i == 14));
         check($sformatf("rate chg busy e%0d", i), busy, (i < 16));
         check($sformatf("rate chg underrun e%0d", i), underrun, 1'b0);
      end

      // clear_state_i in FIRST_HALF, then a fresh bit proves the timer restarted.
      settle(1'b1, 1'b1);
      @(negedge clk); gen_en = 1'b1; data_valid = 1'b1; data = 1'b1; rate = RATE_COUNTER_WIDTH'(4);
      edge_wait();
      check("clear accept io", io, 1'b0);
      check("clear accept fall", falling_edge, 1'b1);
      @(negedge clk); data_valid = 1'b0;
      edge_wait();
      @(negedge clk); clear_state = 1'b1;
      edge_wait();
      check("clear io", io, 1'b1);
      check("clear rise", rising_edge, 1'b1);
      check("clear busy", busy, 1'b0);
      check("clear underrun", underrun, 1'b0);
      @(negedge clk); clear_state = 1'b0;
      #1;
      check("post clear ready", data_ready, 1'b1);
      edge_wait();
      check("post clear underrun", underrun, 1'b0);
      @(negedge clk); data_valid = 1'b1; data = 1'b0; rate = RATE_COUNTER_WIDTH'(2);
      edge_wait();
      check("reaccept io", io, 1'b1);
      check("reaccept any", any_edge, 1'b0);
      check("reaccept busy", busy, 1'b1);
      @(negedge clk); data_valid = 1'b0; gen_en = 1'b0;
      edge_wait();
      edge_wait();
      check("reaccept hold io", io, 1'b1);
      edge_wait();
      check("reaccept mid io", io, 1'b0);
      check("reaccept mid pulse", mid_bit, 1'b1);
      edge_wait();
      edge_wait();
      edge_wait();
      check("reaccept end io", io, 1'b1);
      check("reaccept end busy", busy, 1'b0);

      // Asynchronous reset in the middle of a high clock-mode half.
      settle(1'b0, 1'b0);
      @(negedge clk); gen_en = 1'b1; rate = RATE_COUNTER_WIDTH'(3);
      edge_wait();
      edge_wait();
      check("pre-reset io", io, 1'b1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async reset io", io, 1'b0);
      check("async reset busy", busy, 1'b0);
      check("async reset rise", rising_edge, 1'b0);
      @(negedge clk); gen_en = 1'b0; rst_n = 1'b1;
      edge_wait();
      check("after reset busy", busy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_rate_generator
